pipe_sched: RTL
===============

# pipe_sched

Pipeline sequencer between the decode-stage control unit and the EX-stage iterative multiplier. It keeps the multi-cycle multiplier occupied for a programmable number of cycles and holds IF/ID and EX while it runs. It squashes wrong-path instructions after a taken branch (opcode 12) or jump (opcode 11) resolves in EX, by forcing the decode instruction to the all-zero nop. It also keeps a saturating count of stall cycles for debug.

## Interface
Parameters:
- MUL_LAT, 8: total EX cycles a multiply occupies, legal range 2..15.
- FLUSH_CYCLES, 1: extra squash cycles after the redirect cycle, legal range 1..3.

Ports:
- clk  in  1  Pipeline clock; all state changes on the rising edge.
- rst_n  in  1  Reset. Asynchronous, active-low.
- id_inst  in  16  Instruction in decode; [15:12] is the opcode.
- id_valid  in  1  id_inst holds a real instruction.
- ex_redirect  in  1  A taken branch or a jump is resolving in EX this cycle.
- stall_if  out  1  Hold PC and the IF/ID register.
- hold_ex  out  1  Hold the EX register; send a bubble to WB.
- flush_id  out  1  Replace the decode instruction, and its control word, with 16'h0000.
- mul_start  out  1  One-cycle pulse: the multiply in ID enters EX.
- mul_busy  out  1  Multiplier occupied.
- mul_done  out  1  Last multiply cycle; the result is valid for forwarding.
- stall_cycles  out  16  Count of cycles with stall_if=1, saturating at 16'hFFFF.

## Operation
- States:
  - RUN: normal flow.
  - MUL_BUSY: multiply in progress.
  - FLUSH: squashing wrong-path instructions.
- Registered state:
  - state (2 bits).
  - cnt (4 bits), the shared busy/flush down-counter.
  - stall_cycles (16 bits).
- RUN:
  - If ex_redirect=1: flush_id=1, cnt<=FLUSH_CYCLES, go to FLUSH. Redirect has priority over everything else.
  - Else if id_valid=1 and id_inst[15:12]=4'd15: mul_start=1, cnt<=MUL_LAT-1, go to MUL_BUSY. IF/ID is not stalled on the issue cycle.
  - Else all outputs are 0.
- MUL_BUSY:
  - stall_if=1, hold_ex=1, mul_busy=1.
  - mul_done=(cnt==1).
  - cnt decrements each cycle; when cnt==1, go to RUN.
  - ex_redirect and id_* are ignored, because EX holds the multiply.
- FLUSH:
  - flush_id=1; cnt decrements each cycle; when cnt==1, go to RUN.
  - A new ex_redirect reloads cnt<=FLUSH_CYCLES and the block stays in FLUSH.
  - A multiply presented in ID is squashed: no mul_start.
- stall_cycles increments on every cycle with stall_if=1 and holds at 16'hFFFF.
- Opcodes other than 15 never cause a stall here. Register forwarding stays in the control unit.
- An all-zero id_inst is a nop and never issues a multiply.

## Timing
- All outputs except stall_cycles are combinational from state, cnt and the inputs. While rst_n=0 they are forced to 0.
- Reset, asynchronous: state=RUN, cnt=0, stall_cycles=0.
- Multiply issued at cycle T:
  - mul_start at T.
  - mul_busy, stall_if and hold_ex at T+1 .. T+MUL_LAT-1.
  - mul_done at T+MUL_LAT-1.
  - Back in RUN at T+MUL_LAT, where a new multiply may issue immediately.
  - Stall cost per multiply is MUL_LAT-1 cycles.
- Redirect at cycle T: flush_id at T .. T+FLUSH_CYCLES, then RUN.
- Redirect and a multiply in ID in the same RUN cycle: flush only; mul_start=0.
- Reset asserted mid-MUL_BUSY or mid-FLUSH: outputs drop to 0 immediately. No mul_done pulse is produced for the aborted operation.

## Structure
- Shared package pipe_pkg:
  - Opcode constants OP_JUMP=4'd11, OP_BRANCH=4'd12, OP_MUL=4'd15.
  - Constant NOP_INST=16'h0000.
  - State enum {RUN, MUL_BUSY, FLUSH}.
  - Control-word bit-index constants, so that the control unit and this block agree on the Mul bit (bit 10).
- One sub-module: sat_cnt16 (enable, asynchronous active-low reset, saturating 16-bit up-counter) for stall_cycles.
- FSM and cnt live in pipe_sched itself.

## Test plan
- Reset: drive rst_n=0 mid-run. All outputs are 0 within the same cycle and stall_cycles=0. After release, the block is in RUN.
- Multiply, MUL_LAT=8: id_inst=16'hF123, id_valid=1 at T.
  - mul_start at T.
  - stall_if=1 at T+1..T+7.
  - mul_done only at T+7.
  - stall_cycles=7.
  - RUN at T+8.
- Back-to-back multiplies: second 16'hF456 presented at T+8 → mul_start at T+8, stall_cycles=14 after completion.
- Redirect, FLUSH_CYCLES=1: ex_redirect at T → flush_id at T and T+1; stall_if stays 0; a repeat redirect at T+1 extends flush_id to T+2.
- Conflict: ex_redirect=1 with id_inst=16'hF000, id_valid=1 → flush_id=1, mul_start=0, mul_busy stays 0.
- Saturation: MUL_LAT=15, 4682 back-to-back multiplies → stall_cycles reaches 16'hFFFF and holds. Reset during MUL_BUSY clears it and no mul_done appears.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer and the decode-stage control
// unit: opcode values, the nop encoding, the sequencer state encoding and the
// control-word bit positions both sides must agree on.
package pipe_pkg;

  // Opcodes live in inst[15:12].
  localparam logic [3:0] OP_JUMP   = 4'd11;
  localparam logic [3:0] OP_BRANCH = 4'd12;
  localparam logic [3:0] OP_MUL    = 4'd15;

  // The squashed instruction; decodes to an all-zero control word.
  localparam logic [15:0] NOP_INST = 16'h0000;

  // Control-word bit indices produced by the control unit.
  localparam int unsigned CW_REG_WRITE = 0;
  localparam int unsigned CW_MEM_READ  = 1;
  localparam int unsigned CW_MEM_WRITE = 2;
  localparam int unsigned CW_BRANCH    = 8;
  localparam int unsigned CW_JUMP      = 9;
  localparam int unsigned CW_MUL       = 10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_BUSY = 2'd1,
    FLUSH    = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_sched_if.sv
// Decode/EX handshake between the control unit (master) and the pipeline
// sequencer (slave).
//   id_inst, id_valid : instruction currently in decode
//   ex_redirect       : taken branch / jump resolving in EX
//   stall_if, hold_ex, flush_id, mul_start, mul_busy, mul_done : pipeline control
//   stall_cycles      : saturating debug count of IF stall cycles
interface pipe_sched_if;
  logic [15:0] id_inst;
  logic        id_valid;
  logic        ex_redirect;
  logic        stall_if;
  logic        hold_ex;
  logic        flush_id;
  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [15:0] stall_cycles;

  modport master (
    output id_inst, id_valid, ex_redirect,
    input  stall_if, hold_ex, flush_id, mul_start, mul_busy, mul_done, stall_cycles
  );

  modport slave (
    input  id_inst, id_valid, ex_redirect,
    output stall_if, hold_ex, flush_id, mul_start, mul_busy, mul_done, stall_cycles
  );
endinterface

// File: rtl/sat_cnt16.sv
// 16-bit up-counter that sticks at 16'hFFFF.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : count this cycle
//   count      : current value
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_sched.sv
// Pipeline sequencer: keeps the iterative multiplier occupied for MUL_LAT EX
// cycles while holding IF/ID and EX, and squashes the decode instruction for
// the redirect cycle plus FLUSH_CYCLES after a taken branch or jump.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pipe_sched_if.slave (decode inputs, pipeline control outputs,
//                stall_cycles debug counter)
// Parameters: MUL_LAT (2..15), FLUSH_CYCLES (1..3).
module pipe_sched
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT      = 8,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  pipe_sched_if.slave  bus
);

  // The issue cycle is the first of the MUL_LAT cycles, so the counter is
  // loaded with the number of cycles still to go after it.
  localparam logic [3:0] MUL_RELOAD   = 4'(MUL_LAT - 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       is_mul;
  logic       stall_c, hold_c, flush_c, start_c, busy_c, done_c;

  assign is_mul = bus.id_valid && (bus.id_inst[15:12] == OP_MUL);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    hold_c  = 1'b0;
    flush_c = 1'b0;
    start_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;

    unique case (state_q)
      RUN: begin
        // A redirect wins: the multiply in ID is on the wrong path.
        if (bus.ex_redirect) begin
          flush_c = 1'b1;
          cnt_d   = FLUSH_RELOAD;
          state_d = FLUSH;
        end else if (is_mul) begin
          start_c = 1'b1;
          cnt_d   = MUL_RELOAD;
          state_d = MUL_BUSY;
        end
      end

      MUL_BUSY: begin
        // EX holds the multiply, so redirects and ID contents are not looked at.
        stall_c = 1'b1;
        hold_c  = 1'b1;
        busy_c  = 1'b1;
        done_c  = (cnt_q == 4'd1);
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end

      FLUSH: begin
        flush_c = 1'b1;
        if (bus.ex_redirect) begin
          cnt_d = FLUSH_RELOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RUN;
        end
      end

      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are masked by rst_n so an aborted multiply or flush stops driving
  // the pipeline in the same cycle reset arrives, not at the next edge.
  assign bus.stall_if  = rst_n & stall_c;
  assign bus.hold_ex   = rst_n & hold_c;
  assign bus.flush_id  = rst_n & flush_c;
  assign bus.mul_start = rst_n & start_c;
  assign bus.mul_busy  = rst_n & busy_c;
  assign bus.mul_done  = rst_n & done_c;

  sat_cnt16 u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_c),
    .count (bus.stall_cycles)
  );

endmodule
